spike_event_fifo: RTL

- Downstream consumer of the ASO spike detector's 1-bit spike_detected output.
- Converts detector pulses into timestamped spike events:
  - rising-edge detection,
  - refractory-period suppression of re-triggers,
  - DEPTH-entry event FIFO with a valid/ready output for the readout/serializer stage.
- Tracks FIFO overflow with a sticky flag and a saturating drop counter.

---
 rtl/spike_event_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spike_event_fifo.sv
// Spike event FIFO: timestamps rising edges of the ASO detector output, applies a
// refractory hold-off and queues events behind a valid/ready port for readout.
module spike_event_fifo #(
   parameter int unsigned TS_WIDTH       = 16,
   parameter int unsigned REFRACT_CYCLES = 32,
   parameter int unsigned DEPTH          = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                spike_detected,
   input  logic                evt_ready,
   input  logic                ovf_clear,
   output logic                evt_valid,
   output logic [TS_WIDTH-1:0] evt_data,
   output logic                overflow,
   output logic [7:0]          drop_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned RW = 16;
   localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT_CYCLES - 1);

   typedef enum logic {IDLE, REFRACTORY} state_t;

   state_t                state, state_next;
   logic [TS_WIDTH-1:0]   ts;
   logic                  spike_prev;
   logic                  spike_edge;
   logic                  accept;
   logic [RW-1:0]         refr_cnt;

   logic [TS_WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0]         count, count_next;
   logic                  full, push, pop, drop;

   assign spike_edge = spike_detected & ~spike_prev;

   // Free-running timestamp and edge-detect history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts         <= '0;
         spike_prev <= 1'b0;
      end else begin
         spike_prev <= spike_detected;
         if (enable) ts <= ts + TS_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (enable && spike_edge && (REFRACT_CYCLES > 1)) state_next = REFRACTORY;
         REFRACTORY: if (refr_cnt == RW'(1)) state_next = IDLE;
         default:    state_next = IDLE;
      endcase
      if (!enable) state_next = IDLE;
   end

   always_comb begin
      accept = 1'b0;
      if (state == IDLE && enable && spike_edge) accept = 1'b1;
   end

   // Counts down the cycles still blocked after an accepted event
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                refr_cnt <= '0;
      else if (!enable)       refr_cnt <= '0;
      else if (accept)        refr_cnt <= REFRACT_LOAD;
      else if (refr_cnt != 0) refr_cnt <= refr_cnt - RW'(1);
   end

   assign full    = (count == CW'(DEPTH));
   assign pop     = evt_valid & evt_ready;
   assign push    = accept & (~full | pop);
   assign drop    = accept & full & ~pop;
   assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ts;
   end

   // Registered show-ahead head; a push into an emptying FIFO forwards ts directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         evt_valid <= 1'b0;
         evt_data  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr    <= rd_next;
         count     <= count_next;
         evt_valid <= (count_next != 0);
         evt_data  <= (push && (wr_ptr == rd_next)) ? ts : mem[rd_next];
      end
   end

   // Sticky overflow and saturating drop counter; a drop beats a coincident clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (ovf_clear)                drop_count <= 8'd1;
         else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (ovf_clear) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule
